// File: rtl/fir_pkg.sv
// Shared types for the FIR sample feeder: fp32 sample word, feeder FSM states
// and the {last, data} entry stored in the sample FIFO.
// Pure declarations; no logic, no latency, no flow control.
package fir_pkg;

    typedef logic [31:0] fp32_t;

    localparam fp32_t FP32_ZERO = 32'h0;

    typedef enum logic [1:0] {
        PRIME,
        STREAM,
        PAD,
        DONE
    } feeder_state_t;

    typedef struct packed {
        logic  last;
        fp32_t data;
    } fir_sample_t;

endpackage

// File: rtl/sync_fifo.sv
// Generic synchronous FIFO, power-of-two DEPTH, head word visible combinationally.
// Latency: a pushed word is visible at o_head_dat on the cycle after the push edge.
// Backpressure: pushes while full and pops while empty are ignored; o_full gates the producer.
// Ports: clk/rst (sync, active-high), i_push/i_push_dat write side,
//        i_pop/o_head_dat read side, o_full/o_empty/o_count occupancy.
module sync_fifo #(
    parameter int WIDTH = 33,
    parameter int DEPTH = 16,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_dat,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_head_dat,
    output logic             o_full,
    output logic             o_empty,
    output logic [AW:0]      o_count
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_full     = (r_count == (AW+1)'(DEPTH));
    assign o_empty    = (r_count == '0);
    assign o_count    = r_count;
    assign o_head_dat = r_mem[r_rd_ptr];
    assign w_do_push  = i_push & ~o_full;
    assign w_do_pop   = i_pop & ~o_empty;

    // Storage carries no reset; only the pointers and count define validity.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_push_dat;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/fir_sample_feeder.sv
// Feeds buffered fp32 samples to the FIR one at a time, advancing on each rising fir_next.
// Latency: new sample on fir_in one cycle after the request edge; first sample primed without a request.
// Backpressure: s_ready drops when the FIFO is full; an empty FIFO at a request yields +0.0 and counts an underrun.
// Ports: clk/rst (sync, active-high); s_valid/s_ready/s_data/s_last upstream stream;
//        fir_next request in, fir_in/fir_stop sample out; fill_level, underrun_cnt, done status.
// Build option: define FEEDER_ZERO_PAD_EN to append NTAPS-1 zero samples after the last real one.
module fir_sample_feeder
    import fir_pkg::*;
#(
    parameter int DEPTH       = 16,
    parameter int MAX_SAMPLES = 145,
    parameter int NTAPS       = 146,
    localparam int CW         = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          s_valid,
    output logic          s_ready,
    input  logic [31:0]   s_data,
    input  logic          s_last,
    input  logic          fir_next,
    output logic [31:0]   fir_in,
    output logic          fir_stop,
    output logic [CW-1:0] fill_level,
    output logic [15:0]   underrun_cnt,
    output logic          done
);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("fir_sample_feeder: DEPTH must be a power of two >= 2");
    end
    if (MAX_SAMPLES < 1 || MAX_SAMPLES > 256) begin : g_bad_max
        $error("fir_sample_feeder: MAX_SAMPLES must be 1..256");
    end
    if (NTAPS < 2) begin : g_bad_ntaps
        $error("fir_sample_feeder: NTAPS must be >= 2");
    end

    localparam logic [7:0] CAP_IDX = 8'(MAX_SAMPLES - 1);

    feeder_state_t r_state, w_state_nxt;
    fp32_t         r_fir_in, w_fir_in_nxt;
    logic          r_fir_stop, w_fir_stop_nxt;
    logic [7:0]    r_count, w_count_nxt;
    logic [15:0]   r_underrun_cnt, w_underrun_nxt;
    logic          r_next_q;
    logic          w_req;
    logic          w_pop;
    logic          w_full;
    logic          w_empty;
    fir_sample_t   w_head;

`ifdef FEEDER_ZERO_PAD_EN
    localparam int PW = $clog2(NTAPS) + 1;
    localparam logic [PW-1:0] PAD_LAST = PW'(NTAPS - 1);
    logic [PW-1:0] r_pad_cnt, w_pad_cnt_nxt;
`endif

    sync_fifo #(
        .WIDTH ($bits(fir_sample_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .i_push     (s_valid & s_ready),
        .i_push_dat ({s_last, s_data}),
        .i_pop      (w_pop),
        .o_head_dat (w_head),
        .o_full     (w_full),
        .o_empty    (w_empty),
        .o_count    (fill_level)
    );

    // r_next_q resets to 1 so a FIR holding next high out of reset is not a request.
    assign w_req        = fir_next & ~r_next_q;
    assign s_ready      = ~rst & ~w_full;
    assign fir_in       = r_fir_in;
    assign fir_stop     = r_fir_stop;
    assign underrun_cnt = r_underrun_cnt;
    assign done         = (r_state == DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= PRIME;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_next_q       <= 1'b1;
            r_fir_in       <= FP32_ZERO;
            r_fir_stop     <= 1'b0;
            r_count        <= '0;
            r_underrun_cnt <= '0;
`ifdef FEEDER_ZERO_PAD_EN
            r_pad_cnt      <= '0;
`endif
        end else begin
            r_next_q       <= fir_next;
            r_fir_in       <= w_fir_in_nxt;
            r_fir_stop     <= w_fir_stop_nxt;
            r_count        <= w_count_nxt;
            r_underrun_cnt <= w_underrun_nxt;
`ifdef FEEDER_ZERO_PAD_EN
            r_pad_cnt      <= w_pad_cnt_nxt;
`endif
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_fir_in_nxt   = r_fir_in;
        w_fir_stop_nxt = r_fir_stop;
        w_count_nxt    = r_count;
        w_underrun_nxt = r_underrun_cnt;
        w_pop          = 1'b0;
`ifdef FEEDER_ZERO_PAD_EN
        w_pad_cnt_nxt  = r_pad_cnt;
`endif
        case (r_state)
            // Requests are ignored here; the first sample is loaded as soon as one exists.
            PRIME: begin
                if (!w_empty) begin
                    w_pop          = 1'b1;
                    w_fir_in_nxt   = w_head.data;
                    w_fir_stop_nxt = w_head.last | (r_count == CAP_IDX);
                    w_count_nxt    = r_count + 1'b1;
                    w_state_nxt    = STREAM;
                end
            end
            STREAM: begin
                if (w_req) begin
                    if (r_fir_stop) begin
                        w_fir_in_nxt   = FP32_ZERO;
`ifdef FEEDER_ZERO_PAD_EN
                        w_state_nxt    = PAD;
                        w_pad_cnt_nxt  = PW'(1);
                        w_fir_stop_nxt = (PAD_LAST == PW'(1));
`else
                        w_state_nxt    = DONE;
                        w_fir_stop_nxt = 1'b1;
`endif
                    end else if (!w_empty) begin
                        w_pop          = 1'b1;
                        w_fir_in_nxt   = w_head.data;
                        w_fir_stop_nxt = w_head.last | (r_count == CAP_IDX);
                        w_count_nxt    = r_count + 1'b1;
                    end else begin
                        // Underrun: the FIR still gets a sample slot, filled with +0.0.
                        w_fir_in_nxt   = FP32_ZERO;
                        w_fir_stop_nxt = 1'b0;
                        w_count_nxt    = r_count + 1'b1;
                        if (r_underrun_cnt != 16'hFFFF) begin
                            w_underrun_nxt = r_underrun_cnt + 1'b1;
                        end
                    end
                end
            end
`ifdef FEEDER_ZERO_PAD_EN
            PAD: begin
                if (w_req) begin
                    w_fir_in_nxt = FP32_ZERO;
                    if (r_fir_stop) begin
                        w_state_nxt    = DONE;
                        w_fir_stop_nxt = 1'b1;
                    end else begin
                        w_pad_cnt_nxt  = r_pad_cnt + 1'b1;
                        w_fir_stop_nxt = (r_pad_cnt + 1'b1 == PAD_LAST);
                    end
                end
            end
`endif
            DONE: begin
                w_fir_in_nxt   = FP32_ZERO;
                w_fir_stop_nxt = 1'b1;
            end
            default: begin
                w_state_nxt = PRIME;
            end
        endcase
    end

endmodule

// File: tb/tb_fir_sample_feeder.sv
module tb_fir_sample_feeder;

    logic        clk = 1'b0;
    logic        rst;
    logic        s_valid;
    logic        s_ready;
    logic [31:0] s_data;
    logic        s_last;
    logic        fir_next;
    logic [31:0] fir_in;
    logic        fir_stop;
    logic [4:0]  fill_level;
    logic [15:0] underrun_cnt;
    logic        done;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    fir_sample_feeder #(
        .DEPTH       (16),
        .MAX_SAMPLES (145),
        .NTAPS       (146)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .s_valid      (s_valid),
        .s_ready      (s_ready),
        .s_data       (s_data),
        .s_last       (s_last),
        .fir_next     (fir_next),
        .fir_in       (fir_in),
        .fir_stop     (fir_stop),
        .fill_level   (fill_level),
        .underrun_cnt (underrun_cnt),
        .done         (done)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] d, input logic l);
        s_valid = 1'b1;
        s_data  = d;
        s_last  = l;
        tick();
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    // One low cycle so the next high is a fresh edge, then the request edge.
    task automatic pulse();
        fir_next = 1'b0;
        tick();
        fir_next = 1'b1;
        tick();
        fir_next = 1'b0;
    endtask

    initial begin
        int pushed;
        int nreq;
        logic prev;
        logic acc;

        // ---------------- reset; FIR holds next high as it would after its own reset
        rst = 1'b1; s_valid = 1'b0; s_data = '0; s_last = 1'b0; fir_next = 1'b1;
        tick(); tick();
        chk("rst_s_ready",  32'(s_ready), 32'd0);
        chk("rst_fir_in",   fir_in, 32'h0);
        chk("rst_fir_stop", 32'(fir_stop), 32'd0);
        chk("rst_done",     32'(done), 32'd0);
        chk("rst_fill",     32'(fill_level), 32'd0);
        chk("rst_underrun", 32'(underrun_cnt), 32'd0);
        rst = 1'b0;
        tick();
        chk("post_rst_s_ready", 32'(s_ready), 32'd1);

        // ---------------- prime, with fir_next still held high
        push(32'h3F80_0000, 1'b0);
        chk("push1_fill", 32'(fill_level), 32'd1);
        tick();
        chk("prime_fir_in",   fir_in, 32'h3F80_0000);
        chk("prime_fir_stop", 32'(fir_stop), 32'd0);
        chk("prime_fill",     32'(fill_level), 32'd0);

        push(32'h4000_0000, 1'b0);
        push(32'h4040_0000, 1'b1);
        tick();
        chk("held_after_rst_fir_in", fir_in, 32'h3F80_0000);
        chk("stream_fill2",          32'(fill_level), 32'd2);

        // ---------------- held request: 5 cycles high gives one advance
        fir_next = 1'b0;
        tick();
        fir_next = 1'b1;
        tick();
        chk("adv1_fir_in",   fir_in, 32'h4000_0000);
        chk("adv1_fir_stop", 32'(fir_stop), 32'd0);
        chk("adv1_fill",     32'(fill_level), 32'd1);
        repeat (4) tick();
        chk("held5_fir_in", fir_in, 32'h4000_0000);
        chk("held5_fill",   32'(fill_level), 32'd1);
        fir_next = 1'b0;
        repeat (3) tick();
        chk("stable_fir_in", fir_in, 32'h4000_0000);

        pulse();
        chk("adv2_fir_in",   fir_in, 32'h4040_0000);
        chk("adv2_fir_stop", 32'(fir_stop), 32'd1);
        chk("adv2_fill",     32'(fill_level), 32'd0);

        pulse();
        chk("done_flag",     32'(done), 32'd1);
        chk("done_fir_in",   fir_in, 32'h0);
        chk("done_fir_stop", 32'(fir_stop), 32'd1);

        // FIFO keeps filling in DONE; further requests change nothing
        push(32'h40A0_0000, 1'b0);
        chk("done_push_fill", 32'(fill_level), 32'd1);
        pulse();
        chk("done_sticky",       32'(done), 32'd1);
        chk("done_sticky_fill",  32'(fill_level), 32'd1);
        chk("done_sticky_fir",   fir_in, 32'h0);

        // ---------------- reset abandons stream and discards FIFO
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        chk("rst2_fill", 32'(fill_level), 32'd0);
        chk("rst2_done", 32'(done), 32'd0);

        // ---------------- underrun
        push(32'h3F80_0000, 1'b0);
        tick();
        chk("ur_prime_fir_in", fir_in, 32'h3F80_0000);
        pulse();
        chk("ur_fir_in",   fir_in, 32'h0);
        chk("ur_cnt1",     32'(underrun_cnt), 32'd1);
        chk("ur_fir_stop", 32'(fir_stop), 32'd0);
        push(32'h4080_0000, 1'b0);
        chk("ur_refill", 32'(fill_level), 32'd1);
        pulse();
        chk("ur_recover_fir_in", fir_in, 32'h4080_0000);
        chk("ur_recover_cnt",    32'(underrun_cnt), 32'd1);

        // push into empty FIFO on the request cycle: no bypass, counts as underrun
        fir_next = 1'b0;
        tick();
        s_valid = 1'b1; s_data = 32'h40C0_0000; fir_next = 1'b1;
        tick();
        s_valid = 1'b0; fir_next = 1'b0;
        chk("simul_fir_in", fir_in, 32'h0);
        chk("simul_cnt",    32'(underrun_cnt), 32'd2);
        chk("simul_fill",   32'(fill_level), 32'd1);
        pulse();
        chk("simul_next_fir_in", fir_in, 32'h40C0_0000);

        // ---------------- sample cap: 150 pushed, 145 delivered
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        pushed = 0;
        nreq   = 0;
        prev   = 1'b0;
        for (int cyc = 0; cyc < 2000 && nreq < 144; cyc++) begin
            s_valid  = (pushed < 150);
            s_data   = 32'h4000_0000 | 32'(pushed);
            s_last   = 1'b0;
            fir_next = (cyc >= 2) && cyc[0];
            acc      = s_valid && s_ready;
            @(posedge clk);
            if (acc) pushed++;
            if (fir_next && !prev) nreq++;
            prev = fir_next;
            #1;
            if (fir_next && nreq == 143) begin
                chk("cap143_fir_in",   fir_in, 32'h4000_008F);
                chk("cap143_fir_stop", 32'(fir_stop), 32'd0);
            end
        end
        s_valid = 1'b0;
        chk("cap_req_budget",   32'(nreq), 32'd144);
        chk("cap144_fir_in",    fir_in, 32'h4000_0090);
        chk("cap144_fir_stop",  32'(fir_stop), 32'd1);
        chk("cap_no_underrun",  32'(underrun_cnt), 32'd0);
        fir_next = 1'b0;
        tick();
        chk("cap_fill_left", 32'(fill_level), 32'd5);
        fir_next = 1'b1;
        tick();
        fir_next = 1'b0;
        chk("cap_done",      32'(done), 32'd1);
        chk("cap_done_fill", 32'(fill_level), 32'd5);
        chk("cap_done_fir",  fir_in, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
